// File: rtl/msdf_mult_arbiter.sv
// -----------------------------------------------------------------------------
// msdf_mult_arbiter
//   Shares one MSDF multiplier between two elastic requesters. A requester is
//   pending when both its A and B operand streams present a valid token. One
//   requester is granted for a whole operation: its operand streams are passed
//   straight through to the multiplier and the product stream is routed back to
//   it. When both the operand input and the product output have seen their
//   "last" tokens the block returns to IDLE and re-arbitrates round-robin.
//
//   Token format (DATA_WIDTH = 3): bit 2 = last, bits 1:0 = signed digit.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   reqN_a_* / reqN_b_*           operand streams from requester N (data/valid in, ready out)
//   resN_*                        product stream to requester N (data/valid out, ready in)
//   mul_a_* / mul_b_*             operand streams to the multiplier
//   mul_res_*                     product stream from the multiplier
//   grant                         requester owning the multiplier (meaningful while busy)
//   busy                          1 while an operation is in progress (FEED or DRAIN)
//   ops0_cnt, ops1_cnt            completed-operation counters, only when
//                                 MSDF_ARB_STATS_EN is defined
//
// Build option
//   MSDF_ARB_STATS_EN : adds the 16-bit wrapping per-requester operation counters.
// -----------------------------------------------------------------------------
module msdf_mult_arbiter #(
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] req0_a_data,
    input  logic                  req0_a_valid,
    output logic                  req0_a_ready,
    input  logic [DATA_WIDTH-1:0] req0_b_data,
    input  logic                  req0_b_valid,
    output logic                  req0_b_ready,
    input  logic [DATA_WIDTH-1:0] req1_a_data,
    input  logic                  req1_a_valid,
    output logic                  req1_a_ready,
    input  logic [DATA_WIDTH-1:0] req1_b_data,
    input  logic                  req1_b_valid,
    output logic                  req1_b_ready,
    output logic [DATA_WIDTH-1:0] res0_data,
    output logic                  res0_valid,
    input  logic                  res0_ready,
    output logic [DATA_WIDTH-1:0] res1_data,
    output logic                  res1_valid,
    input  logic                  res1_ready,
    output logic [DATA_WIDTH-1:0] mul_a_data,
    output logic                  mul_a_valid,
    input  logic                  mul_a_ready,
    output logic [DATA_WIDTH-1:0] mul_b_data,
    output logic                  mul_b_valid,
    input  logic                  mul_b_ready,
    input  logic [DATA_WIDTH-1:0] mul_res_data,
    input  logic                  mul_res_valid,
    output logic                  mul_res_ready,
    output logic                  grant,
`ifdef MSDF_ARB_STATS_EN
    output logic [15:0]           ops0_cnt,
    output logic [15:0]           ops1_cnt,
`endif
    output logic                  busy
);

    localparam int LAST = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant_nxt;
    logic   prio, prio_nxt;
    logic   res_last_seen, res_last_seen_nxt;
    logic   pend0, pend1;
    logic   route;
    logic   in_last, res_last, op_done;

    assign pend0 = req0_a_valid & req0_b_valid;
    assign pend1 = req1_a_valid & req1_b_valid;
    // Product digits overlap the operand input (online delay), so the result
    // path is live in both FEED and DRAIN.
    assign route = (state == FEED) || (state == DRAIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            grant         <= 1'b0;
            prio          <= 1'b0;
            res_last_seen <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            prio          <= prio_nxt;
            res_last_seen <= res_last_seen_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        grant_nxt         = grant;
        prio_nxt          = prio;
        res_last_seen_nxt = res_last_seen;
        busy              = route;
        req0_a_ready      = 1'b0;
        req0_b_ready      = 1'b0;
        req1_a_ready      = 1'b0;
        req1_b_ready      = 1'b0;
        mul_a_data        = '0;
        mul_a_valid       = 1'b0;
        mul_b_data        = '0;
        mul_b_valid       = 1'b0;
        res0_data         = '0;
        res0_valid        = 1'b0;
        res1_data         = '0;
        res1_valid        = 1'b0;
        mul_res_ready     = 1'b0;
        in_last           = 1'b0;
        res_last          = 1'b0;
        op_done           = 1'b0;

        case (state)
            IDLE: begin
                // Priority holder wins if pending, otherwise the other one.
                if (pend0 | pend1) begin
                    grant_nxt = (prio ? pend1 : pend0) ? prio : ~prio;
                    state_nxt = FEED;
                end
            end
            FEED: begin
                if (grant) begin
                    mul_a_data   = req1_a_data;
                    mul_a_valid  = req1_a_valid;
                    mul_b_data   = req1_b_data;
                    mul_b_valid  = req1_b_valid;
                    req1_a_ready = mul_a_ready;
                    req1_b_ready = mul_b_ready;
                end else begin
                    mul_a_data   = req0_a_data;
                    mul_a_valid  = req0_a_valid;
                    mul_b_data   = req0_b_data;
                    mul_b_valid  = req0_b_valid;
                    req0_a_ready = mul_a_ready;
                    req0_b_ready = mul_b_ready;
                end
                // Only A's last flag delimits the operation input.
                in_last = mul_a_valid & mul_a_ready & mul_a_data[LAST];
            end
            DRAIN: ;
            default: state_nxt = IDLE;
        endcase

        if (route) begin
            if (grant) begin
                res1_data     = mul_res_data;
                res1_valid    = mul_res_valid;
                mul_res_ready = res1_ready;
            end else begin
                res0_data     = mul_res_data;
                res0_valid    = mul_res_valid;
                mul_res_ready = res0_ready;
            end
            res_last = mul_res_valid & mul_res_ready & mul_res_data[LAST];
        end

        if (state == FEED) begin
            if (in_last) begin
                if (res_last_seen | res_last) op_done = 1'b1;
                else                          state_nxt = DRAIN;
            end else if (res_last) begin
                res_last_seen_nxt = 1'b1;
            end
        end
        if ((state == DRAIN) && res_last) op_done = 1'b1;

        if (op_done) begin
            state_nxt         = IDLE;
            prio_nxt          = ~grant;
            res_last_seen_nxt = 1'b0;
        end
    end

`ifdef MSDF_ARB_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ops0_cnt <= 16'd0;
            ops1_cnt <= 16'd0;
        end else if (op_done) begin
            if (grant) ops1_cnt <= ops1_cnt + 16'd1;
            else       ops0_cnt <= ops0_cnt + 16'd1;
        end
    end
`endif

endmodule
